// File: rtl/ysyx_22051013_csr.sv
// Machine-mode CSR unit: mstatus/mtvec/mepc/mcause/mcycle with ecall/mret sequencing.
// Define YSYX_22051013_MCYCLE_EN to build the free-running mcycle counter.
module ysyx_22051013_csr (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [3:0]  csr_ctl,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    input  logic [63:0] pc_i,
    output logic [63:0] rdata_o,
    output logic        done_o,
    output logic        redirect_valid_o,
    output logic [63:0] redirect_pc_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TRAP = 2'd1;
    localparam logic [1:0] S_RET  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MCYCLE  = 12'hB00;

    localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;
    localparam int MIE  = 3;
    localparam int MPIE = 7;

    logic [1:0]  r_state;
    logic [63:0] r_mstatus;
    logic [63:0] r_mtvec;
    logic [63:0] r_mepc;
    logic [63:0] r_mcause;
    logic [63:0] r_rdata;
    logic [63:0] r_pc;
    logic [63:0] r_redirect_pc;
    logic        r_redirect;

    logic        w_accept;
    logic        w_wr_ena;
    logic        w_rd_ena;
    logic        w_ecall;
    logic        w_mret;
    logic [63:0] w_old;
    logic [63:0] w_new;
    logic [63:0] w_mcycle;

    assign w_wr_ena = csr_ctl[3];
    assign w_rd_ena = csr_ctl[2];
    assign w_ecall  = csr_ctl[1];
    assign w_mret   = csr_ctl[0];
    assign ready_o  = (r_state == S_IDLE);
    assign w_accept = valid_i & ready_o;

`ifdef YSYX_22051013_MCYCLE_EN
    logic [63:0] r_mcycle;

    // A software write wins over the increment on the same edge.
    always_ff @(posedge clk) begin
        if (rst)
            r_mcycle <= '0;
        else if (w_accept && w_wr_ena && csr_addr == A_MCYCLE)
            r_mcycle <= w_new;
        else
            r_mcycle <= r_mcycle + 64'd1;
    end

    assign w_mcycle = r_mcycle;
`else
    assign w_mcycle = '0;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_old = '0;
        case (csr_addr)
            A_MSTATUS: w_old = r_mstatus;
            A_MTVEC:   w_old = r_mtvec;
            A_MEPC:    w_old = r_mepc;
            A_MCAUSE:  w_old = r_mcause;
            A_MCYCLE:  w_old = w_mcycle;
            default:   w_old = '0;
        endcase
    end

    always_comb begin
        w_new = csr_wdata;
        case (csr_op)
            2'b01:   w_new = w_old | csr_wdata;
            2'b10:   w_new = w_old & ~csr_wdata;
            default: w_new = csr_wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_mstatus     <= MSTATUS_RST;
            r_mtvec       <= '0;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_rdata       <= '0;
            r_pc          <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rdata    <= w_rd_ena ? w_old : '0;
                        r_pc       <= pc_i;
                        r_redirect <= w_ecall | w_mret;
                        if (w_wr_ena) begin
                            case (csr_addr)
                                A_MSTATUS: r_mstatus <= w_new;
                                A_MTVEC:   r_mtvec   <= {w_new[63:2], 2'b00};
                                A_MEPC:    r_mepc    <= {w_new[63:2], 2'b00};
                                A_MCAUSE:  r_mcause  <= w_new;
                                default:   ;
                            endcase
                        end
                        if (w_ecall)
                            r_state <= S_TRAP;
                        else if (w_mret)
                            r_state <= S_RET;
                        else
                            r_state <= S_RESP;
                    end
                end
                S_TRAP: begin
                    r_mepc            <= {r_pc[63:2], 2'b00};
                    r_mcause          <= 64'd11;
                    r_mstatus[MPIE]   <= r_mstatus[MIE];
                    r_mstatus[MIE]    <= 1'b0;
                    r_mstatus[12:11]  <= 2'b11;
                    r_redirect_pc     <= {r_mtvec[63:2], 2'b00};
                    r_state           <= S_RESP;
                end
                S_RET: begin
                    r_mstatus[MIE]    <= r_mstatus[MPIE];
                    r_mstatus[MPIE]   <= 1'b1;
                    r_mstatus[12:11]  <= 2'b11;
                    r_redirect_pc     <= r_mepc;
                    r_state           <= S_RESP;
                end
                default: begin
                    r_redirect    <= 1'b0;
                    r_redirect_pc <= '0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign rdata_o          = r_rdata;
    assign done_o           = (r_state == S_RESP);
    assign redirect_valid_o = done_o & r_redirect;
    assign redirect_pc_o    = redirect_valid_o ? r_redirect_pc : '0;

endmodule

// File: tb/tb_ysyx_22051013_csr.sv
// Scoreboard bench for ysyx_22051013_csr: a driver pushes model predictions, a monitor checks each done_o.
// Build with or without YSYX_22051013_MCYCLE_EN; the model follows the same macro.
module tb_ysyx_22051013_csr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [3:0]  csr_ctl = '0;
    logic [1:0]  csr_op = '0;
    logic [11:0] csr_addr = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] pc_i = '0;
    logic [63:0] rdata_o;
    logic        done_o;
    logic        redirect_valid_o;
    logic [63:0] redirect_pc_o;

    ysyx_22051013_csr dut (
        .clk              (clk),
        .rst              (rst),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .csr_ctl          (csr_ctl),
        .csr_op           (csr_op),
        .csr_addr         (csr_addr),
        .csr_wdata        (csr_wdata),
        .pc_i             (pc_i),
        .rdata_o          (rdata_o),
        .done_o           (done_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected response of one accepted request.
    typedef struct {
        int unsigned cyc;
        logic [63:0] rdata;
        logic        rv;
        logic [63:0] rpc;
    } exp_t;
    exp_t sb[$];

    // Architectural model.
    localparam logic [3:0] C_WR = 4'b1000, C_RD = 4'b0100, C_ECALL = 4'b0010, C_MRET = 4'b0001;
    logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, mc_base;
    int unsigned mc_edge;

    function automatic logic [63:0] m_read(input logic [11:0] addr, input int unsigned n);
        case (addr)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef YSYX_22051013_MCYCLE_EN
            12'hB00: return mc_base + 64'(n - mc_edge - 1);
`endif
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_accept(input logic [3:0] ctl, input logic [1:0] op, input logic [11:0] addr,
                                input logic [63:0] wd, input logic [63:0] pc, input int unsigned a);
        exp_t e;
        logic [63:0] old, nv;
        old = m_read(addr, a);
        nv = (op == 2'b01) ? (old | wd) : (op == 2'b10) ? (old & ~wd) : wd;
        if (ctl[3]) begin
            case (addr)
                12'h300: m_mstatus = nv;
                12'h305: m_mtvec = nv & ~64'd3;
                12'h341: m_mepc = nv & ~64'd3;
                12'h342: m_mcause = nv;
`ifdef YSYX_22051013_MCYCLE_EN
                12'hB00: begin mc_base = nv; mc_edge = a; end
`endif
                default: ;
            endcase
        end
        e.rdata = ctl[2] ? old : 64'd0;
        e.rv = 1'b0;
        e.rpc = 64'd0;
        e.cyc = a + 1;
        if (ctl[1]) begin
            m_mepc = pc & ~64'd3;
            m_mcause = 64'd11;
            m_mstatus[7] = m_mstatus[3];
            m_mstatus[3] = 1'b0;
            m_mstatus[12:11] = 2'b11;
            e.rv = 1'b1;
            e.rpc = m_mtvec & ~64'd3;
            e.cyc = a + 2;
        end else if (ctl[0]) begin
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
            m_mstatus[12:11] = 2'b11;
            e.rv = 1'b1;
            e.rpc = m_mepc;
            e.cyc = a + 2;
        end
        sb.push_back(e);
    endtask

    // Monitor: compares whenever the DUT signals completion.
    always @(negedge clk) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'd0, done_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("rdata", rdata_o, e.rdata);
                check("redirect_valid", {63'd0, redirect_valid_o}, {63'd0, e.rv});
                check("redirect_pc", redirect_pc_o, e.rpc);
            end
        end else begin
            check("idle_redirect", {redirect_valid_o, redirect_pc_o[62:0]}, 64'd0);
            if (sb.size() > 0 && cyc > sb[0].cyc) begin
                check("done_timeout", 64'(cyc), 64'(sb[0].cyc));
                void'(sb.pop_front());
            end
        end
    end

    task automatic do_reset(input int edges);
        rst = 1'b1;
        valid_i = 1'b0;
        sb.delete();
        repeat (edges) @(posedge clk);
        mc_edge = cyc;
        mc_base = 64'd0;
        m_mstatus = 64'h0000_000A_0000_1800;
        m_mtvec = 64'd0;
        m_mepc = 64'd0;
        m_mcause = 64'd0;
        #1 rst = 1'b0;
    endtask

    task automatic issue(input logic [3:0] ctl, input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] wd, input logic [63:0] pc);
        int guard = 0;
        @(negedge clk);
        csr_ctl = ctl; csr_op = op; csr_addr = addr; csr_wdata = wd; pc_i = pc;
        valid_i = 1'b1;
        while (!ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) begin
            check("ready_timeout", {63'd0, ready_o}, 64'd1);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(ctl, op, addr, wd, pc, cyc);
        #1 valid_i = 1'b0;
    endtask

    task automatic read_all();
        issue(C_RD, 2'b00, 12'h300, 64'd0, 64'd0);
        issue(C_RD, 2'b00, 12'h305, 64'd0, 64'd0);
        issue(C_RD, 2'b00, 12'h341, 64'd0, 64'd0);
        issue(C_RD, 2'b00, 12'h342, 64'd0, 64'd0);
        issue(C_RD, 2'b00, 12'hB00, 64'd0, 64'd0);
    endtask

    initial begin
        logic [11:0] addrs [6];
        int guard;
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
        addrs[3] = 12'h342; addrs[4] = 12'hB00; addrs[5] = 12'h7C0;

        do_reset(3);
        @(negedge clk);
        check("rst_ready", {63'd0, ready_o}, 64'd1);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_rdata", rdata_o, 64'd0);
        check("rst_redirect_pc", redirect_pc_o, 64'd0);

        // csrrs mstatus after reset, then csrrw mtvec with low bits set
        issue(C_WR | C_RD, 2'b01, 12'h300, 64'h8, 64'd0);
        issue(C_WR | C_RD, 2'b00, 12'h305, 64'h8000_0103, 64'd0);
        issue(C_RD, 2'b00, 12'h300, 64'd0, 64'd0);
        issue(C_RD, 2'b00, 12'h305, 64'd0, 64'd0);

        // ecall with MIE=1; ready stays low through TRAP and RESP
        issue(C_ECALL, 2'b00, 12'h000, 64'd0, 64'h8000_0040);
        @(negedge clk);
        check("ecall_ready_trap", {63'd0, ready_o}, 64'd0);
        @(negedge clk);
        check("ecall_ready_resp", {63'd0, ready_o}, 64'd0);
        read_all();

        // mret back to mepc=0x8000_0044
        issue(C_WR, 2'b00, 12'h341, 64'h8000_0044, 64'd0);
        issue(C_MRET, 2'b00, 12'h000, 64'd0, 64'h8000_0100);
        issue(C_RD, 2'b00, 12'h300, 64'd0, 64'd0);

        // reset while in TRAP aborts the ecall
        issue(C_ECALL, 2'b00, 12'h000, 64'd0, 64'h8000_0080);
        do_reset(1);
        @(negedge clk);
        check("abort_ready", {63'd0, ready_o}, 64'd1);
        check("abort_done", {63'd0, done_o}, 64'd0);
        check("abort_redirect", {63'd0, redirect_valid_o}, 64'd0);
        read_all();

        // mcycle wrap: write all ones, read back-to-back
        issue(C_WR, 2'b00, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        issue(C_RD, 2'b00, 12'hB00, 64'd0, 64'd0);
        issue(C_RD, 2'b00, 12'hB00, 64'd0, 64'd0);

        // unimplemented address, reserved op, no-op
        issue(C_WR | C_RD, 2'b11, 12'h7C0, 64'h1234, 64'd0);
        issue(C_WR | C_RD, 2'b11, 12'h342, 64'h5555, 64'd0);
        issue(4'b0000, 2'b00, 12'h300, 64'hFFFF, 64'd0);
        issue(C_RD, 2'b00, 12'h300, 64'd0, 64'd0);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] ctl;
            ctl = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) != 0) ctl[1:0] = 2'b00;
            issue(ctl, 2'($urandom_range(0, 3)), addrs[$urandom_range(0, 5)],
                  {$urandom, $urandom}, {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22051013_csr.md
YSYX_22051013_CSR -- requirements
Module: ysyx_22051013_csr

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port: clk  in  1  system clock.
REQ-003 SHALL have port: rst  in  1  synchronous reset, active-high.
REQ-004 SHALL have port: valid_i  in  1  request from decode/execute.
REQ-005 SHALL have port: ready_o  out  1  request accepted when valid_i & ready_o.
REQ-006 SHALL have port: csr_ctl  in  4  {wr_ena, rd_ena, ecall_ena, mret_ena}, as produced by the decode stage.
REQ-007 SHALL have port: csr_op  in  2  00 RW, 01 RS, 10 RC, 11 reserved (treated as RW).
REQ-008 SHALL have port: csr_addr  in  12  CSR address.
REQ-009 SHALL have port: csr_wdata  in  64  rs1 data or zero-extended zimm.
REQ-010 SHALL have port: pc_i  in  64  PC of the requesting instruction.
REQ-011 SHALL have port: rdata_o  out  64  old CSR value (registered).
REQ-012 SHALL have port: done_o  out  1  one-cycle completion pulse.
REQ-013 SHALL have port: redirect_valid_o  out  1  PC redirect, asserted with done_o.
REQ-014 SHALL have port: redirect_pc_o  out  64  redirect target.

Function
REQ-015 SHALL implement mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342 and mcycle 0xB00 (see REQ-033); other addresses SHALL read 0 and ignore writes.
REQ-016 SHALL run an FSM with states IDLE, TRAP, RET and RESP; ready_o=1 only in IDLE.
REQ-017 IDLE transitions on accept: ecall_ena -> TRAP; else mret_ena -> RET; else -> RESP. ecall_ena has priority when both are set.
REQ-018 On an accept edge with rd_ena=1, SHALL latch the pre-write CSR value into rdata_o; with rd_ena=0, rdata_o SHALL be 0.
REQ-019 On an accept edge with wr_ena=1, SHALL write: RW new=wdata; RS new=old|wdata; RC new=old&~wdata.
REQ-020 Writes to mtvec and mepc SHALL force bits[1:0] to 00.
REQ-021 TRAP (1 cycle): at exit edge SHALL set mepc=latched pc_i with [1:0]=00, mcause=64'd11, mstatus.MPIE=MIE, MIE=0, MPP=2'b11; SHALL then go to RESP with redirect_pc_o={mtvec[63:2],2'b00}.
REQ-022 RET (1 cycle): at exit edge SHALL set mstatus.MIE=MPIE, MPIE=1, MPP=2'b11; SHALL then go to RESP with redirect_pc_o=mepc.
REQ-023 RESP (1 cycle): done_o=1; redirect_valid_o=1 only for ecall/mret; then -> IDLE.
REQ-024 Latency from the accept edge to done_o: CSR access or no-op = 1 cycle; ecall/mret = 2 cycles.
REQ-025 SHALL ignore valid_i while ready_o=0; the initiator holds its request.
REQ-026 A no-op request (csr_ctl=0) SHALL complete in RESP with rdata_o=0 and no CSR change.
REQ-027 Outside RESP, done_o, redirect_valid_o and redirect_pc_o SHALL be 0.

Reset
REQ-028 On rst, SHALL go to state IDLE.
REQ-029 On rst, SHALL set ready_o=1 on the next cycle, with done_o=0, redirect_valid_o=0, rdata_o=0 and redirect_pc_o=0.
REQ-030 On rst, SHALL set mstatus=64'h0000_000A_0000_1800.
REQ-031 On rst, SHALL set mtvec=0, mepc=0, mcause=0 and mcycle=0.
REQ-032 A reset asserted in TRAP, RET or RESP SHALL abort the operation, producing no done_o and no redirect.

Configuration
REQ-033 With macro YSYX_22051013_MCYCLE_EN defined:
- mcycle SHALL increment every non-reset cycle and wrap from 2^64-1 to 0.
- A software write SHALL take precedence over the increment in the same cycle.
- A read SHALL return the value before that edge's increment.
Without the macro, mcycle SHALL read 0, writes to it SHALL be ignored, and no counter SHALL be synthesized.

Verification
REQ-034 Bench SHALL cover: csrrw mtvec, wdata=0x8000_0103 -> done_o 1 cycle after accept, rdata_o=0, mtvec=0x8000_0100.
REQ-035 Bench SHALL cover: csrrs mstatus, wdata=0x8 after reset -> rdata_o=0xA_0000_1800, mstatus=0xA_0000_1808.
REQ-036 Bench SHALL cover: ecall at pc_i=0x8000_0040, mtvec=0x8000_0100, MIE=1 -> done_o plus redirect to 0x8000_0100 at accept+2, mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1, ready_o low for 2 cycles.
REQ-037 Bench SHALL cover: mret with mepc=0x8000_0044, MPIE=1 -> redirect to 0x8000_0044, MIE=1, MPIE=1.
REQ-038 Bench SHALL cover: rst asserted in TRAP -> no done_o or redirect, all CSRs at reset values, ready_o=1 next cycle.
REQ-039 Bench SHALL cover, with YSYX_22051013_MCYCLE_EN: write mcycle=0xFFFF_FFFF_FFFF_FFFF -> reads 0 two cycles later; without the macro, reads 0 always.
